// File: rtl/mydiv_seq.sv
// mydiv_seq: sequential signed fixed-point divider, c = a / b.
// Restoring radix-2 division on magnitudes, one quotient bit per cycle,
// sign applied and result clamped when the quotient is registered.
//
// Handshakes: an operand pair transfers on a rising edge where
// in_valid && in_ready; a result transfers on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE, and out_valid is
// high only in DONE. c/div_zero/sat are held constant while out_valid is high.
module mydiv_seq #(
    parameter int a_bits  = 16,
    parameter int a_point = 8,
    parameter int b_bits  = 16,
    parameter int b_point = 8,
    parameter int c_bits  = 16,
    parameter int c_point = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [a_bits-1:0] a,
    input  logic [b_bits-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [c_bits-1:0] c,
    output logic              div_zero,
    output logic              sat
);

    localparam int SHIFT  = c_point - a_point + b_point;
    localparam int SH_POS = (SHIFT > 0) ? SHIFT : 0;
    localparam int SH_NEG = (SHIFT < 0) ? -SHIFT : 0;
    localparam int NW     = a_bits + SH_POS;           // scaled numerator width
    localparam int RW     = b_bits + 2;                // remainder width
    localparam int EW     = ((NW > RW) ? NW : RW) + c_bits;
    localparam int CW     = $clog2(c_bits + 1);

    localparam logic [c_bits-1:0] MAX_C = {1'b0, {(c_bits-1){1'b1}}};
    localparam logic [c_bits-1:0] MIN_C = {1'b1, {(c_bits-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [c_bits-1:0] nq_q, nq_d;       // numerator bits shift out, quotient bits shift in
    logic [b_bits:0]   d_q, d_d;
    logic              neg_q, neg_d;
    logic              a_neg_q, a_neg_d;
    logic              a_zero_q, a_zero_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic [c_bits-1:0] c_q, c_d;
    logic              div_zero_q, div_zero_d;
    logic              sat_q, sat_d;

    logic [a_bits:0]   a_sx, a_mag;
    logic [b_bits:0]   b_sx, b_mag;
    logic [EW-1:0]     n_ext, d_ext;
    logic              ovf_load;
    logic [RW-1:0]     rem_sh, d_cmp;
    logic              rem_ge;
    logic [c_bits-1:0] res_c;
    logic              res_sat;

    // Operand magnitudes, scaled numerator and load-time overflow detection.
    always_comb begin
        a_sx     = {a[a_bits-1], a};
        b_sx     = {b[b_bits-1], b};
        a_mag    = a[a_bits-1] ? -a_sx : a_sx;
        b_mag    = b[b_bits-1] ? -b_sx : b_sx;
        n_ext    = {{(EW-a_bits-1){1'b0}}, a_mag};
        n_ext    = n_ext << SH_POS;
        n_ext    = n_ext >> SH_NEG;
        d_ext    = {{(EW-b_bits-1){1'b0}}, b_mag};
        d_ext    = d_ext << c_bits;
        ovf_load = (n_ext >= d_ext);
    end

    // One restoring step; a set remainder MSB means it already exceeds D.
    always_comb begin
        rem_sh = {rem_q[RW-2:0], nq_q[c_bits-1]};
        d_cmp  = {1'b0, d_q};
        rem_ge = rem_q[RW-1] | (rem_sh >= d_cmp);
    end

    // Sign application and clamp of the finished magnitude quotient.
    always_comb begin
        res_c   = '0;
        res_sat = 1'b0;
        if (dz_q) begin
            res_c = a_zero_q ? '0 : (a_neg_q ? MIN_C : MAX_C);
        end else if (ovf_q) begin
            res_c   = neg_q ? MIN_C : MAX_C;
            res_sat = 1'b1;
        end else if (neg_q) begin
            if (nq_q > MIN_C) begin
                res_c   = MIN_C;
                res_sat = 1'b1;
            end else begin
                res_c = -nq_q;
            end
        end else if (nq_q[c_bits-1]) begin
            res_c   = MAX_C;
            res_sat = 1'b1;
        end else begin
            res_c = nq_q;
        end
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        nq_d       = nq_q;
        d_d        = d_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        a_zero_d   = a_zero_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        c_d        = c_q;
        div_zero_d = div_zero_q;
        sat_d      = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Upper numerator bits seed the remainder; they are below D
                    // whenever there is no overflow, so c_bits steps suffice.
                    rem_d    = n_ext[c_bits+RW-1:c_bits];
                    nq_d     = n_ext[c_bits-1:0];
                    d_d      = b_mag;
                    neg_d    = a[a_bits-1] ^ b[b_bits-1];
                    a_neg_d  = a[a_bits-1];
                    a_zero_d = (a == '0);
                    dz_d     = (b == '0);
                    ovf_d    = ovf_load;
                    count_d  = CW'(c_bits);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (count_q != '0) begin
                    rem_d   = rem_ge ? (rem_sh - d_cmp) : rem_sh;
                    nq_d    = {nq_q[c_bits-2:0], rem_ge};
                    count_d = count_q - 1'b1;
                end else begin
                    // Extra cycle after the last step registers the final result.
                    c_d        = res_c;
                    div_zero_d = dz_q;
                    sat_d      = res_sat;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            nq_q       <= '0;
            d_q        <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            a_zero_q   <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            c_q        <= '0;
            div_zero_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            nq_q       <= nq_d;
            d_q        <= d_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            a_zero_q   <= a_zero_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            c_q        <= c_d;
            div_zero_q <= div_zero_d;
            sat_q      <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign c         = c_q;
    assign div_zero  = div_zero_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mydiv_seq.sv
// Self-checking bench for mydiv_seq at default parameters (16/8 operands).
module tb_mydiv_seq;

    localparam int AB = 16;
    localparam int CB = 16;
    localparam int SH = 8;      // c_point - a_point + b_point
    localparam int LAT = CB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AB-1:0] a = '0;
    logic [AB-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CB-1:0] c;
    logic          div_zero;
    logic          sat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int av;
        int bv;
        int ec;
        bit edz;
        bit esat;
    } vec_t;

    mydiv_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .div_zero(div_zero), .sat(sat)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the quotient definition.
    task automatic model(input int av, input int bv, output int ec, output bit edz, output bit esat);
        longint na, nb, num, q;
        longint maxv, minv;
        maxv = (longint'(1) << (CB - 1)) - 1;
        minv = -(longint'(1) << (CB - 1));
        edz  = 1'b0;
        esat = 1'b0;
        if (bv == 0) begin
            edz = 1'b1;
            q = (av > 0) ? maxv : ((av < 0) ? minv : 0);
        end else begin
            na  = (av < 0) ? -longint'(av) : longint'(av);
            nb  = (bv < 0) ? -longint'(bv) : longint'(bv);
            num = na * (longint'(1) << SH);
            q   = num / nb;
            if ((av < 0) != (bv < 0)) q = -q;
            if (q > maxv) begin q = maxv; esat = 1'b1; end
            if (q < minv) begin q = minv; esat = 1'b1; end
        end
        ec = int'(q);
    endtask

    // One full transaction; 'hold' cycles of backpressure in DONE with a
    // stray in_valid presented meanwhile.
    task automatic do_op(input int av, input int bv, input int hold,
                         output int cv, output bit dzv, output bit satv, output int lat);
        int w;
        logic [CB-1:0] c_hold;
        @(negedge clk);
        a = AB'(av);
        b = AB'(bv);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = AB'($urandom);
        b = AB'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) chk("done_timeout", 0, 1);
        cv   = $signed(c);
        dzv  = div_zero;
        satv = sat;
        c_hold = c;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = AB'($urandom);
            b = AB'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_c", c, c_hold);
            chk("hold_dz", div_zero, dzv);
            chk("hold_sat", sat, satv);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        vec_t vecs[$];
        int cv, lat, ec, av, bv, n_ov, w;
        bit dzv, satv, edz, esat;
        int acc[$];

        vecs.push_back('{768, 512, 384, 1'b0, 1'b0});
        vecs.push_back('{-768, 512, -384, 1'b0, 1'b0});
        vecs.push_back('{768, -512, -384, 1'b0, 1'b0});
        vecs.push_back('{1, 512, 0, 1'b0, 1'b0});
        vecs.push_back('{-1, 512, 0, 1'b0, 1'b0});
        vecs.push_back('{32767, 1, 32767, 1'b0, 1'b1});
        vecs.push_back('{-32768, 1, -32768, 1'b0, 1'b1});
        vecs.push_back('{-32768, -256, 32767, 1'b0, 1'b1});
        vecs.push_back('{100, 0, 32767, 1'b1, 1'b0});
        vecs.push_back('{-5, 0, -32768, 1'b1, 1'b0});
        vecs.push_back('{0, 0, 0, 1'b1, 1'b0});
        vecs.push_back('{-256, -256, 256, 1'b0, 1'b0});

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_sat", sat, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", in_ready, 1);

        // Directed vectors; the first one also runs with 5 cycles of backpressure.
        foreach (vecs[i]) begin
            do_op(vecs[i].av, vecs[i].bv, (i == 0) ? 5 : 0, cv, dzv, satv, lat);
            chk($sformatf("vec%0d_c", i), cv, vecs[i].ec);
            chk($sformatf("vec%0d_dz", i), dzv, vecs[i].edz);
            chk($sformatf("vec%0d_sat", i), satv, vecs[i].esat);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
        end

        // Back-to-back with out_ready held high: accept E, result visible after
        // E+17, handshake at E+18, next accept at E+19.
        @(negedge clk);
        a = AB'(768);
        b = AB'(512);
        in_valid = 1'b1;
        out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 45; i++) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid) begin
                n_ov++;
                chk("b2b_c", $signed(c), 384);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 3);
        if (acc.size() >= 2) chk("b2b_interval", acc[1] - acc[0], CB + 3);
        chk("b2b_results", n_ov, 2);
        w = 0;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_drain", in_ready, 1);
        out_ready = 1'b0;

        // Reset four cycles after accept aborts the operation.
        @(negedge clk);
        a = AB'(768);
        b = AB'(512);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_c", c, 0);
        chk("abort_dz", div_zero, 0);
        chk("abort_sat", sat, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        out_ready = 1'b0;
        chk("abort_no_result", n_ov, 0);
        chk("abort_in_ready_after", in_ready, 1);
        do_op(512, 256, 0, cv, dzv, satv, lat);
        chk("after_abort_c", cv, 512);
        chk("after_abort_flags", {dzv, satv}, 0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            av = $signed(16'($urandom));
            case ($urandom_range(0, 5))
                0: bv = 0;
                1: bv = $urandom_range(0, 6) - 3;
                2: bv = $signed(16'($urandom)) >>> $urandom_range(4, 12);
                default: bv = $signed(16'($urandom));
            endcase
            if ($urandom_range(0, 4) == 0) av = av >>> $urandom_range(4, 14);
            model(av, bv, ec, edz, esat);
            do_op(av, bv, $urandom_range(0, 2), cv, dzv, satv, lat);
            chk($sformatf("rnd%0d_c a=%0d b=%0d", i, av, bv), cv, ec);
            chk($sformatf("rnd%0d_dz", i), dzv, edz);
            chk($sformatf("rnd%0d_sat", i), satv, esat);
            chk($sformatf("rnd%0d_latency", i), lat, LAT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
